// File: rtl/water_flow_supervisor.sv
// ---------------------------------------------------------------------------
// water_flow_supervisor
//
// Watches the water-level sensor and checks that it moves the way the
// current mode says it should. Fill must rise and drain must fall by at
// least THRESHOLD counts within TIME_LIMIT monitor cycles. Hold must stay
// within HOLD_TOL of the level captured at the baseline. A level above
// MAX_LEVEL is an overflow in every mode. The first fault is latched in
// err_code until software pulses err_clr, and each fault entry is counted.
//
// Ports
//   clk                 in   rising-edge system clock
//   reset               in   asynchronous, active-low reset
//   enable              in   supervisor enable
//   mode                in   [1:0] 00 idle, 01 fill, 10 drain, 11 hold
//   water_level_sensor  in   [LEVEL_W-1:0] current water level
//   err_clr             in   single-cycle pulse; acknowledges a latched fault
//   error_flag          out  high while in FAULT
//   err_code            out  [2:0] 0 none, 1 fill stall, 2 drain stall,
//                                  3 leak, 4 overflow, 5 inflow
//   progress            out  one-cycle pulse when the baseline advances
//   timer               out  [CNT_W-1:0] non-progress cycles since baseline
//   fault_count         out  [7:0] FAULT entries, saturating at 255
//   state_dbg           out  [1:0] current FSM state (IDLE/BASELINE/MONITOR/FAULT)
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module water_flow_supervisor #(
  parameter int LEVEL_W    = 10,
  parameter int THRESHOLD  = 10,
  parameter int TIME_LIMIT = 5,
  parameter int HOLD_TOL   = 4,
  parameter int MAX_LEVEL  = 1000,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  input  logic               err_clr,
  output logic               error_flag,
  output logic [2:0]         err_code,
  output logic               progress,
  output logic [CNT_W-1:0]   timer,
  output logic [7:0]         fault_count,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BASELINE = 2'd1;
  localparam logic [1:0] ST_MONITOR  = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_FILL  = 2'b01;
  localparam logic [1:0] MODE_DRAIN = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [2:0] CODE_NONE        = 3'd0;
  localparam logic [2:0] CODE_FILL_STALL  = 3'd1;
  localparam logic [2:0] CODE_DRAIN_STALL = 3'd2;
  localparam logic [2:0] CODE_LEAK        = 3'd3;
  localparam logic [2:0] CODE_OVERFLOW    = 3'd4;
  localparam logic [2:0] CODE_INFLOW      = 3'd5;

  // Level arithmetic is done one bit wider than the sensor so that
  // baseline+THRESHOLD and sensor+THRESHOLD can never wrap.
  localparam int XW = LEVEL_W + 1;
  localparam logic [XW-1:0]    THR_X     = XW'(THRESHOLD);
  localparam logic [XW-1:0]    TOL_X     = XW'(HOLD_TOL);
  localparam logic [XW-1:0]    MAX_X     = XW'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TIME_LIMIT - 1);

  logic [1:0]         state_q, state_d;
  logic [LEVEL_W-1:0] baseline_q, baseline_d;
  logic [1:0]         last_mode_q, last_mode_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               error_flag_q, error_flag_d;
  logic [2:0]         err_code_q, err_code_d;
  logic               progress_q, progress_d;
  logic [7:0]         fault_count_q, fault_count_d;

  logic [XW-1:0] sen_x;
  logic [XW-1:0] base_x;
  logic          active;
  logic          overflow;
  logic          fill_prog;
  logic          drain_prog;
  logic          leak;
  logic          inflow;
  logic          fault_go;
  logic [2:0]    fault_code;

  assign sen_x      = {1'b0, water_level_sensor};
  assign base_x     = {1'b0, baseline_q};
  assign active     = enable && (mode != MODE_IDLE);
  assign overflow   = sen_x > MAX_X;
  assign fill_prog  = sen_x >= (base_x + THR_X);
  // A baseline below THRESHOLD can never satisfy this, which is intended.
  assign drain_prog = (sen_x + THR_X) <= base_x;
  assign leak       = (base_x > sen_x) && ((base_x - sen_x) > TOL_X);
  assign inflow     = (sen_x > base_x) && ((sen_x - base_x) > TOL_X);

  always_comb begin
    state_d       = state_q;
    baseline_d    = baseline_q;
    last_mode_d   = last_mode_q;
    timer_d       = timer_q;
    error_flag_d  = error_flag_q;
    err_code_d    = err_code_q;
    progress_d    = 1'b0;
    fault_count_d = fault_count_q;
    fault_go      = 1'b0;
    fault_code    = CODE_NONE;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (active) begin
          state_d = ST_BASELINE;
        end
      end

      ST_BASELINE: begin
        timer_d = '0;
        if (!active) begin
          state_d = ST_IDLE;
        end else begin
          baseline_d  = water_level_sensor;
          last_mode_d = mode;
          state_d     = ST_MONITOR;
        end
      end

      ST_MONITOR: begin
        if (!active) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (overflow) begin
          fault_go   = 1'b1;
          fault_code = CODE_OVERFLOW;
        end else if (mode != last_mode_q) begin
          // A commanded mode switch restarts supervision instead of faulting.
          state_d = ST_BASELINE;
          timer_d = '0;
        end else if ((mode == MODE_FILL && fill_prog) ||
                     (mode == MODE_DRAIN && drain_prog)) begin
          // Progress beats a timeout that would otherwise land this cycle.
          baseline_d = water_level_sensor;
          timer_d    = '0;
          progress_d = 1'b1;
        end else if (mode == MODE_HOLD) begin
          if (leak) begin
            fault_go   = 1'b1;
            fault_code = CODE_LEAK;
          end else if (inflow) begin
            fault_go   = 1'b1;
            fault_code = CODE_INFLOW;
          end else if (timer_q != '1) begin
            // Hold never times out; the timer just saturates.
            timer_d = timer_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_q == LAST_TICK) begin
            fault_go   = 1'b1;
            fault_code = (mode == MODE_FILL) ? CODE_FILL_STALL : CODE_DRAIN_STALL;
          end
        end
      end

      ST_FAULT: begin
        // Only an explicit acknowledge leaves FAULT; mode/enable are ignored.
        if (err_clr) begin
          error_flag_d = 1'b0;
          err_code_d   = CODE_NONE;
          timer_d      = '0;
          state_d      = active ? ST_BASELINE : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    if (fault_go) begin
      state_d      = ST_FAULT;
      error_flag_d = 1'b1;
      err_code_d   = fault_code;
      if (fault_count_q != 8'hFF) begin
        fault_count_d = fault_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      baseline_q    <= '0;
      last_mode_q   <= MODE_IDLE;
      timer_q       <= '0;
      error_flag_q  <= 1'b0;
      err_code_q    <= CODE_NONE;
      progress_q    <= 1'b0;
      fault_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      baseline_q    <= baseline_d;
      last_mode_q   <= last_mode_d;
      timer_q       <= timer_d;
      error_flag_q  <= error_flag_d;
      err_code_q    <= err_code_d;
      progress_q    <= progress_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign error_flag  = error_flag_q;
  assign err_code    = err_code_q;
  assign progress    = progress_q;
  assign timer       = timer_q;
  assign fault_count = fault_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_water_flow_supervisor.sv
// ---------------------------------------------------------------------------
// tb_water_flow_supervisor
//
// Each scenario task drives one input set per clock, pushes the hand-derived
// expected output snapshot to exp_q and the sampled DUT snapshot to obs_q,
// then drains both queues and compares them inline.
// Snapshot layout: {state[1:0], error_flag, err_code[2:0], progress,
//                   timer[15:0], fault_count[7:0]}
// ---------------------------------------------------------------------------
module tb_water_flow_supervisor;

  localparam int W = 31;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [9:0]  water_level_sensor;
  logic        err_clr;
  logic        error_flag;
  logic [2:0]  err_code;
  logic        progress;
  logic [15:0] timer;
  logic [7:0]  fault_count;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  string        tag_q[$];

  int checks_total;
  int checks_passed;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  water_flow_supervisor dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .mode               (mode),
    .water_level_sensor (water_level_sensor),
    .err_clr            (err_clr),
    .error_flag         (error_flag),
    .err_code           (err_code),
    .progress           (progress),
    .timer              (timer),
    .fault_count        (fault_count),
    .state_dbg          (state_dbg)
  );

  function automatic logic [W-1:0] snap();
    return {state_dbg, error_flag, err_code, progress, timer, fault_count};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("st=%0d ef=%0b code=%0d prog=%0b timer=%0d fc=%0d",
                     v[30:29], v[28], v[27:25], v[24], v[23:8], v[7:0]);
  endfunction

  // ---------------- driver ----------------
  // Apply one input set for one clock and record expected vs. sampled output.
  task automatic cyc(input string tag, input logic en, input logic [1:0] md,
                     input int sen, input logic clr,
                     input int st, input logic ef, input int code,
                     input logic prog, input int tmr, input int fc);
    logic [W-1:0] e;
    enable             = en;
    mode               = md;
    water_level_sensor = 10'(sen);
    err_clr            = clr;
    e = {2'(st), ef, 3'(code), prog, 16'(tmr), 8'(fc)};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs_q.push_back(snap());
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string t;
    reset = 1'b0;
    enable = 1'b1;
    mode = 2'b01;
    water_level_sensor = 10'd500;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back('0);
    tag_q.push_back("reset_state");
    obs_q.push_back(snap());
    @(negedge clk);
    reset = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks_total++;
      if (o !== e) $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(e));
      else checks_passed++;
    end
  endtask

  task automatic test_fill_progress();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string t;
    cyc("fill_to_base",  1, 2'b01, 100, 0, 1, 0, 0, 0, 0, 0);
    cyc("fill_base",     1, 2'b01, 100, 0, 2, 0, 0, 0, 0, 0);
    cyc("fill_105",      1, 2'b01, 105, 0, 2, 0, 0, 0, 1, 0);
    cyc("fill_112_prog", 1, 2'b01, 112, 0, 2, 0, 0, 1, 0, 0);
    cyc("fill_112_hold", 1, 2'b01, 112, 0, 2, 0, 0, 0, 1, 0);
    cyc("fill_clr_ign",  1, 2'b01, 121, 1, 2, 0, 0, 0, 2, 0);
    cyc("fill_122_edge", 1, 2'b01, 122, 0, 2, 0, 0, 1, 0, 0);
    cyc("fill_disable",  0, 2'b01, 122, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks_total++;
      if (o !== e) $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(e));
      else checks_passed++;
    end
  endtask

  task automatic test_fill_stall();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string t;
    cyc("stall_to_base", 1, 2'b01, 200, 0, 1, 0, 0, 0, 0, 0);
    cyc("stall_base",    1, 2'b01, 200, 0, 2, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("stall_t%0d", i), 1, 2'b01, 200, 0, 2, 0, 0, 0, i, 0);
    cyc("stall_fault",   1, 2'b01, 200, 0, 3, 1, 1, 0, 5, 1);
    cyc("stall_mode_ign",1, 2'b10, 200, 0, 3, 1, 1, 0, 5, 1);
    cyc("stall_en_ign",  0, 2'b00, 200, 0, 3, 1, 1, 0, 5, 1);
    cyc("stall_clr_idle",0, 2'b00, 200, 1, 0, 0, 0, 0, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks_total++;
      if (o !== e) $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(e));
      else checks_passed++;
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string t;
    cyc("drain_to_base", 1, 2'b10, 5, 0, 1, 0, 0, 0, 0, 1);
    cyc("drain_base5",   1, 2'b10, 5, 0, 2, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("drain_t%0d", i), 1, 2'b10, 0, 0, 2, 0, 0, 0, i, 1);
    cyc("drain_fault",   1, 2'b10, 0, 0, 3, 1, 2, 0, 5, 2);
    cyc("drain_clr_base",1, 2'b10, 300, 1, 1, 0, 0, 0, 0, 2);
    cyc("drain_base300", 1, 2'b10, 300, 0, 2, 0, 0, 0, 0, 2);
    cyc("drain_291",     1, 2'b10, 291, 0, 2, 0, 0, 0, 1, 2);
    cyc("drain_290_prog",1, 2'b10, 290, 0, 2, 0, 0, 1, 0, 2);
    cyc("drain_290_low", 1, 2'b10, 290, 0, 2, 0, 0, 0, 1, 2);
    cyc("drain_to_fill", 1, 2'b01, 290, 0, 1, 0, 0, 0, 0, 2);
    cyc("drain_idle",    0, 2'b00, 290, 0, 0, 0, 0, 0, 0, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks_total++;
      if (o !== e) $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(e));
      else checks_passed++;
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string t;
    cyc("hold_to_base",  1, 2'b11, 400, 0, 1, 0, 0, 0, 0, 2);
    cyc("hold_base400",  1, 2'b11, 400, 0, 2, 0, 0, 0, 0, 2);
    cyc("hold_396_ok",   1, 2'b11, 396, 0, 2, 0, 0, 0, 1, 2);
    cyc("hold_404_ok",   1, 2'b11, 404, 0, 2, 0, 0, 0, 2, 2);
    cyc("hold_395_leak", 1, 2'b11, 395, 0, 3, 1, 3, 0, 2, 3);
    cyc("hold_clr_base", 1, 2'b11, 395, 1, 1, 0, 0, 0, 0, 3);
    cyc("hold_base395",  1, 2'b11, 395, 0, 2, 0, 0, 0, 0, 3);
    cyc("hold_395_ok",   1, 2'b11, 395, 0, 2, 0, 0, 0, 1, 3);
    cyc("hold_inflow",   1, 2'b11, 400, 0, 3, 1, 5, 0, 1, 4);
    cyc("hold_clr_wins", 1, 2'b11, 400, 1, 1, 0, 0, 0, 0, 4);
    cyc("hold_idle",     0, 2'b00, 400, 0, 0, 0, 0, 0, 0, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks_total++;
      if (o !== e) $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(e));
      else checks_passed++;
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string t;
    cyc("ovf_to_base",   1, 2'b01, 500, 0, 1, 0, 0, 0, 0, 4);
    cyc("ovf_base500",   1, 2'b01, 500, 0, 2, 0, 0, 0, 0, 4);
    cyc("ovf_1000_prog", 1, 2'b01, 1000, 0, 2, 0, 0, 1, 0, 4);
    cyc("ovf_1001",      1, 2'b01, 1001, 0, 3, 1, 4, 0, 0, 5);
    cyc("ovf_mode_ign",  1, 2'b10, 1001, 0, 3, 1, 4, 0, 0, 5);
    cyc("ovf_en_ign",    0, 2'b01, 0, 0, 3, 1, 4, 0, 0, 5);
    cyc("ovf_clr_idle",  0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks_total++;
      if (o !== e) $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(e));
      else checks_passed++;
    end
  endtask

  task automatic test_mode_change_and_reset();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string t;
    cyc("mc_to_base",    1, 2'b01, 50, 0, 1, 0, 0, 0, 0, 5);
    cyc("mc_base",       1, 2'b01, 50, 0, 2, 0, 0, 0, 0, 5);
    for (int i = 1; i <= 3; i++)
      cyc($sformatf("mc_t%0d", i), 1, 2'b01, 50, 0, 2, 0, 0, 0, i, 5);
    cyc("mc_switch",     1, 2'b10, 50, 0, 1, 0, 0, 0, 0, 5);
    cyc("mc_rebase",     1, 2'b10, 50, 0, 2, 0, 0, 0, 0, 5);
    cyc("mc_ovf_fault",  1, 2'b10, 1023, 0, 3, 1, 4, 0, 0, 6);
    reset = 1'b0;
    #2;
    exp_q.push_back('0);
    tag_q.push_back("mc_reset_fault");
    obs_q.push_back(snap());
    @(negedge clk);
    reset = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks_total++;
      if (o !== e) $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(e));
      else checks_passed++;
    end
  endtask

  // Repeated overflow faults, acknowledged straight back into BASELINE,
  // until fault_count saturates. Sensor values above the limit are randomised.
  task automatic test_back_to_back();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string t;
    int fc;
    int sen;
    fc = 0;
    cyc("b2b_to_base", 1, 2'b01, 1023, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) begin
      sen = $urandom_range(1023, 1001);
      cyc($sformatf("b2b_mon%0d", i), 1, 2'b01, sen, 0, 2, 0, 0, 0, 0, fc);
      fc = (fc < 255) ? fc + 1 : 255;
      cyc($sformatf("b2b_flt%0d", i), 1, 2'b01, sen, 0, 3, 1, 4, 0, 0, fc);
      cyc($sformatf("b2b_clr%0d", i), 1, 2'b01, sen, 1, 1, 0, 0, 0, 0, fc);
    end
    cyc("b2b_idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 255);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks_total++;
      if (o !== e) $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(e));
      else checks_passed++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks_total  = 0;
    checks_passed = 0;
    test_reset();
    test_fill_progress();
    test_fill_stall();
    test_drain();
    test_hold();
    test_overflow();
    test_mode_change_and_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
